// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: instruction constants, fetch FSM states
// and the IF/ID pipeline record consumed by decode.
package riscv_pkg;

  localparam int          IF_XLEN      = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } if_state_t;

  typedef struct packed {
    logic               valid;
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] pc4;
    logic [31:0]        instr;
  } if_id_t;

  // A bubble decodes as ADDI x0,x0,0 and carries a fixed, harmless PC.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.pc4   = IF_XLEN'(4);
    b.instr = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, flush-to-bubble and asynchronous reset.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Flush wins over hold so a redirect can squash a stalled slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= if_id_bubble();
    end else if (flush) begin
      q <= if_id_bubble();
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM and fetch counter feeding
// the IF/ID register.
module if_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            halted,
  output logic            fault,
  output logic [31:0]     fetch_count
);

  if_state_t       state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pc_plus4;
  logic            fault_n;
  logic [31:0]     count_n;
  logic            hold, flush;
  if_id_t          if_id_p0, if_id_p1;

  assign pc_plus4 = pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      fault       <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fault       <= fault_n;
      halted      <= (state_n == S_HALT);
      fetch_count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    fault_n = fault;
    count_n = fetch_count;
    hold    = 1'b0;
    flush   = 1'b0;
    unique case (state)
      S_BOOT: begin
        flush   = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: begin
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
          fault_n = 1'b1;
          flush   = 1'b1;
          state_n = S_HALT;
        end else if (redirect) begin
          pc_n  = redirect_pc;
          flush = 1'b1;
        end else if (stall) begin
          hold = 1'b1;
        end else begin
          count_n = fetch_count + 32'd1;
          // EBREAK is delivered and counted, but the PC parks on it.
          if (imem_rdata == EBREAK_INSTR) begin
            state_n = S_HALT;
          end else begin
            pc_n = pc_plus4;
          end
        end
      end
      S_HALT: begin
        flush = 1'b1;
      end
      default: begin
        flush   = 1'b1;
        state_n = S_HALT;
      end
    endcase
  end

  // ---- IF -> ID boundary ----
  always_comb begin
    if_id_p0.valid = 1'b1;
    if_id_p0.pc    = pc;
    if_id_p0.pc4   = pc_plus4;
    if_id_p0.instr = imem_rdata;
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .flush (flush),
    .d     (if_id_p0),
    .q     (if_id_p1)
  );

  assign imem_addr   = pc;
  assign if_id_valid = if_id_p1.valid;
  assign if_id_pc    = if_id_p1.pc;
  assign if_id_pc4   = if_id_p1.pc4;
  assign if_id_instr = if_id_p1.instr;

endmodule
